// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: grant encodings and the
// read-return tag that routes memory data back to the requesting port.
package ram_arb_pkg;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_AV0  = 2'b01;
  localparam logic [1:0] GNT_AV1  = 2'b10;

  // zero marks an out-of-range read whose returned word must be forced to 0
  typedef struct packed {
    logic valid;
    logic port;
    logic zero;
  } rd_tag_t;

  localparam int RD_TAG_W = $bits(rd_tag_t);

endpackage

// File: rtl/rr_arb2.sv
// Two-request arbiter with one-hot grant; round-robin by default, fixed
// priority (request 0 always wins) when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    gnt = GNT_NONE;
    if (req[0])      gnt = GNT_AV0;
    else if (req[1]) gnt = GNT_AV1;
  end
`else
  // last = 1 means port 1 holds the most recent grant, so port 0 wins next tie
  logic last;

  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_AV0;
      2'b10:   gnt = GNT_AV1;
      2'b11:   gnt = last ? GNT_AV0 : GNT_AV1;
      default: gnt = GNT_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               last <= 1'b1;
    else if (gnt != GNT_NONE) last <= gnt[1];
  end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between two Avalon-MM slave ports. Build option:
// RAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SEL_BITS = 6,
  parameter int DEPTH         = 32
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_n,
  input  logic                        i_AV0_SlaveSel,
  input  logic [30-ADDR_SEL_BITS-1:0] i_AV0_RegAddr,
  input  logic                        i_AV0_Read,
  input  logic                        i_AV0_Write,
  input  logic [31:0]                 i_AV0_WriteData,
  input  logic [3:0]                  i_AV0_ByteEnable,
  output logic [31:0]                 o_AV0_ReadData,
  output logic                        o_AV0_ReadDataValid,
  output logic                        o_AV0_WaitRequest,
  input  logic                        i_AV1_SlaveSel,
  input  logic [30-ADDR_SEL_BITS-1:0] i_AV1_RegAddr,
  input  logic                        i_AV1_Read,
  input  logic                        i_AV1_Write,
  input  logic [31:0]                 i_AV1_WriteData,
  input  logic [3:0]                  i_AV1_ByteEnable,
  output logic [31:0]                 o_AV1_ReadData,
  output logic                        o_AV1_ReadDataValid,
  output logic                        o_AV1_WaitRequest,
  output logic [30-ADDR_SEL_BITS-1:0] o_Mem_Addr,
  output logic                        o_Mem_RdEn,
  output logic                        o_Mem_WrEn,
  output logic [31:0]                 o_Mem_WrData,
  output logic [3:0]                  o_Mem_ByteEn,
  input  logic [31:0]                 i_Mem_RdData
);

  localparam int          AW      = 30 - ADDR_SEL_BITS;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  function automatic logic in_range(input logic [AW-1:0] addr);
    return {{(32-AW){1'b0}}, addr} < DEPTH_U;
  endfunction

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          gnt_any;
  logic          sel_port;
  logic          g_write;
  logic          g_ok;
  logic [AW-1:0] g_addr;
  logic [31:0]   g_wdata;
  logic [3:0]    g_be;
  rd_tag_t       tag;
  logic [31:0]   rd_data;

  assign req[0] = i_AV0_SlaveSel & (i_AV0_Read | i_AV0_Write);
  assign req[1] = i_AV1_SlaveSel & (i_AV1_Read | i_AV1_Write);

  rr_arb2 u_arb (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign o_AV0_WaitRequest = req[0] & ~gnt[0];
  assign o_AV1_WaitRequest = req[1] & ~gnt[1];

  // Memory command comes straight from the granted port; Read+Write counts as a write
  always_comb begin
    gnt_any      = |gnt;
    sel_port     = gnt[1];
    g_addr       = sel_port ? i_AV1_RegAddr    : i_AV0_RegAddr;
    g_wdata      = sel_port ? i_AV1_WriteData  : i_AV0_WriteData;
    g_be         = sel_port ? i_AV1_ByteEnable : i_AV0_ByteEnable;
    g_write      = sel_port ? i_AV1_Write      : i_AV0_Write;
    g_ok         = in_range(g_addr);
    o_Mem_Addr   = gnt_any ? g_addr  : '0;
    o_Mem_WrData = gnt_any ? g_wdata : '0;
    o_Mem_ByteEn = gnt_any ? g_be    : '0;
    o_Mem_WrEn   = i_Rst_n & gnt_any &  g_write & g_ok;
    o_Mem_RdEn   = i_Rst_n & gnt_any & ~g_write & g_ok;
  end

  // Grant stage -> return stage: tag follows the one-cycle memory latency
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tag <= '0;
    end else begin
      tag.valid <= gnt_any & ~g_write;
      tag.port  <= sel_port;
      tag.zero  <= ~g_ok;
    end
  end

  assign rd_data             = tag.zero ? '0 : i_Mem_RdData;
  assign o_AV0_ReadDataValid = tag.valid & ~tag.port;
  assign o_AV1_ReadDataValid = tag.valid &  tag.port;
  assign o_AV0_ReadData      = o_AV0_ReadDataValid ? rd_data : '0;
  assign o_AV1_ReadData      = o_AV1_ReadDataValid ? rd_data : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model with its own shadow memory.
module tb_ram_port_arbiter;

  localparam int ASB   = 6;
  localparam int DEPTH = 32;
  localparam int AW    = 30 - ASB;
`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sel [2];
  logic          rd [2];
  logic          wr [2];
  logic [AW-1:0] addr [2];
  logic [31:0]   wd [2];
  logic [3:0]    be [2];
  logic [31:0]   rdata [2];
  logic          rvalid [2];
  logic          waitreq [2];
  logic [AW-1:0] o_Mem_Addr;
  logic          o_Mem_RdEn, o_Mem_WrEn;
  logic [31:0]   o_Mem_WrData;
  logic [3:0]    o_Mem_ByteEn;
  logic [31:0]   mem_rd = '0;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_SEL_BITS(ASB), .DEPTH(DEPTH)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_AV0_SlaveSel(sel[0]), .i_AV0_RegAddr(addr[0]), .i_AV0_Read(rd[0]),
    .i_AV0_Write(wr[0]), .i_AV0_WriteData(wd[0]), .i_AV0_ByteEnable(be[0]),
    .o_AV0_ReadData(rdata[0]), .o_AV0_ReadDataValid(rvalid[0]), .o_AV0_WaitRequest(waitreq[0]),
    .i_AV1_SlaveSel(sel[1]), .i_AV1_RegAddr(addr[1]), .i_AV1_Read(rd[1]),
    .i_AV1_Write(wr[1]), .i_AV1_WriteData(wd[1]), .i_AV1_ByteEnable(be[1]),
    .o_AV1_ReadData(rdata[1]), .o_AV1_ReadDataValid(rvalid[1]), .o_AV1_WaitRequest(waitreq[1]),
    .o_Mem_Addr(o_Mem_Addr), .o_Mem_RdEn(o_Mem_RdEn), .o_Mem_WrEn(o_Mem_WrEn),
    .o_Mem_WrData(o_Mem_WrData), .o_Mem_ByteEn(o_Mem_ByteEn), .i_Mem_RdData(mem_rd)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] b);
    merge = old;
    for (int i = 0; i < 4; i++) if (b[i]) merge[8*i +: 8] = nw[8*i +: 8];
  endfunction

  // External single-port RAM with one-cycle read latency; garbage when not reading
  logic [31:0] bmem [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (o_Mem_WrEn)
      bmem[int'(o_Mem_Addr)] <= merge(bmem[int'(o_Mem_Addr)], o_Mem_WrData, o_Mem_ByteEn);
    mem_rd <= o_Mem_RdEn ? bmem[int'(o_Mem_Addr)] : $urandom();
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference model: who wins, what the RAM sees, what each port gets back
  int          m_last = 1;
  bit          m_pend_v = 1'b0;
  int          m_pend_p = 0;
  logic [31:0] m_pend_d = '0;
  logic [31:0] shadow [DEPTH] = '{default: '0};

  task automatic model_step();
    bit r0, r1, gw, ok;
    int g, ga;
    bit ev;
    r0 = sel[0] && (rd[0] || wr[0]);
    r1 = sel[1] && (rd[1] || wr[1]);
    if (!rst_n) begin
      m_last = 1;
      m_pend_v = 1'b0;
    end
    if (r0 && r1)  g = FIXED ? 0 : 1 - m_last;
    else if (r0)   g = 0;
    else if (r1)   g = 1;
    else           g = -1;
    check1("wait0", waitreq[0], r0 && g != 0);
    check1("wait1", waitreq[1], r1 && g != 1);
    for (int p = 0; p < 2; p++) begin
      ev = m_pend_v && m_pend_p == p;
      check1(p == 0 ? "rvalid0" : "rvalid1", rvalid[p], ev);
      check32(p == 0 ? "rdata0" : "rdata1", rdata[p], ev ? m_pend_d : 32'd0);
    end
    gw = 1'b0;
    ok = 1'b0;
    ga = 0;
    if (g >= 0) begin
      gw = wr[g];
      ga = int'(addr[g]);
      ok = ga < DEPTH;
      check1("mem_wren", o_Mem_WrEn, rst_n && gw && ok);
      check1("mem_rden", o_Mem_RdEn, rst_n && !gw && ok);
      check32("mem_addr", 32'(o_Mem_Addr), 32'(addr[g]));
      check32("mem_wdata", o_Mem_WrData, wd[g]);
      check32("mem_be", {28'd0, o_Mem_ByteEn}, {28'd0, be[g]});
    end else begin
      check1("mem_wren_idle", o_Mem_WrEn, 1'b0);
      check1("mem_rden_idle", o_Mem_RdEn, 1'b0);
      check32("mem_addr_idle", 32'(o_Mem_Addr), 32'd0);
      check32("mem_wdata_idle", o_Mem_WrData, 32'd0);
    end
    if (rst_n) begin
      m_pend_v = 1'b0;
      if (g >= 0) begin
        m_last = g;
        if (gw) begin
          if (ok) shadow[ga] = merge(shadow[ga], wd[g], be[g]);
        end else begin
          m_pend_v = 1'b1;
          m_pend_p = g;
          m_pend_d = ok ? shadow[ga] : 32'd0;
        end
      end
    end
  endtask

  always @(negedge clk) if (chk_en) model_step();

  task automatic idle_port(input int p);
    sel[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
    addr[p] = '0; wd[p] = '0; be[p] = '0;
  endtask

  task automatic cmd(input int p, input bit r, input bit w, input int a,
                     input logic [31:0] d, input logic [3:0] b);
    sel[p] = 1'b1; rd[p] = r; wr[p] = w;
    addr[p] = a[AW-1:0]; wd[p] = d; be[p] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit hold [2];
  int ra;

  initial begin
    idle_port(0);
    idle_port(1);
    rst_n = 1'b0;
    chk_en = 1'b1;
    step(); step();
    @(negedge clk);
    check1("rst_rvalid0", rvalid[0], 1'b0);
    check1("rst_rvalid1", rvalid[1], 1'b0);
    check32("rst_rdata0", rdata[0], 32'd0);
    check32("rst_rdata1", rdata[1], 32'd0);

    // Both ports reading continuously out of reset
    step();
    cmd(0, 1, 0, 1, 32'd0, 4'hF);
    cmd(1, 1, 0, 2, 32'd0, 4'hF);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check1("cont_c0_wait0", waitreq[0], 1'b0);
    check1("cont_c0_wait1", waitreq[1], 1'b1);
    step();
    @(negedge clk);
    check1("cont_c1_wait0", waitreq[0], FIXED ? 1'b0 : 1'b1);
    check1("cont_c1_wait1", waitreq[1], FIXED ? 1'b1 : 1'b0);
    check1("cont_c1_rvalid0", rvalid[0], 1'b1);
    step();
    @(negedge clk);
    check1("cont_c2_wait1", waitreq[1], 1'b1);
    check1("cont_c2_rvalid1", rvalid[1], FIXED ? 1'b0 : 1'b1);
    repeat (6) step();
    idle_port(0);
    idle_port(1);
    step();

    // Write on AV0, read back on AV1
    cmd(0, 0, 1, 3, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check1("wr3_wren", o_Mem_WrEn, 1'b1);
    step();
    idle_port(0);
    cmd(1, 1, 0, 3, 32'd0, 4'h0);
    @(negedge clk);
    check1("rd3_rden", o_Mem_RdEn, 1'b1);
    step();
    idle_port(1);
    @(negedge clk);
    check1("rd3_valid", rvalid[1], 1'b1);
    check32("rd3_data", rdata[1], 32'hDEADBEEF);

    // Read+Write together is a write with no response
    step();
    cmd(0, 1, 1, 5, 32'h12345678, 4'hF);
    @(negedge clk);
    check1("rw_wren", o_Mem_WrEn, 1'b1);
    check1("rw_rden", o_Mem_RdEn, 1'b0);
    step();
    cmd(0, 1, 0, 5, 32'd0, 4'h0);
    @(negedge clk);
    check1("rw_novalid", rvalid[0], 1'b0);
    step();
    idle_port(0);
    @(negedge clk);
    check32("rw_readback", rdata[0], 32'h12345678);

    // Out-of-range read and write
    step();
    cmd(0, 1, 0, DEPTH + 1, 32'd0, 4'h0);
    step();
    cmd(0, 0, 1, DEPTH, 32'hAAAA5555, 4'hF);
    @(negedge clk);
    check1("oob_rd_valid", rvalid[0], 1'b1);
    check32("oob_rd_data", rdata[0], 32'd0);
    check1("oob_wr_wren", o_Mem_WrEn, 1'b0);

    // Unselected request is ignored
    step();
    idle_port(0);
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 7;
    @(negedge clk);
    check1("nosel_wait", waitreq[0], 1'b0);
    check1("nosel_wren", o_Mem_WrEn, 1'b0);

    // Reset right after a granted read drops the response
    step();
    cmd(0, 1, 0, 3, 32'd0, 4'h0);
    step();
    idle_port(0);
    rst_n = 1'b0;
    @(negedge clk);
    check1("rstdrop_valid0", rvalid[0], 1'b0);
    check32("rstdrop_data0", rdata[0], 32'd0);
    check32("rstdrop_data1", rdata[1], 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check1("rstdrop_after", rvalid[0], 1'b0);

    // Random traffic; masters hold a stalled request
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      hold[0] = waitreq[0];
      hold[1] = waitreq[1];
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          ra = $urandom_range(0, DEPTH + 3);
          sel[p] = ($urandom_range(0, 7) != 0);
          rd[p] = $urandom_range(0, 1) == 1;
          wr[p] = $urandom_range(0, 2) == 0;
          addr[p] = ra[AW-1:0];
          wd[p] = $urandom();
          be[p] = 4'($urandom_range(0, 15));
        end
      end
      if (c == 400) rst_n = 1'b0;
      if (c == 402) rst_n = 1'b1;
    end

    idle_port(0);
    idle_port(1);
    step();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
- REQ-001 SHALL have parameter ADDR_SEL_BITS, default 6; the word address width is 30-ADDR_SEL_BITS.
- REQ-002 SHALL have parameter DEPTH, default 32; the number of 32-bit words in the backing memory.
- REQ-003 SHALL have port i_Clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-004 SHALL have port i_Rst_n, input, 1 bit: asynchronous active-low reset.
- REQ-005 SHALL have port i_AVn_SlaveSel (n=0,1), input, 1 bit: slave select for Avalon slave port n.
- REQ-006 SHALL have port i_AVn_RegAddr, input, 30-ADDR_SEL_BITS bits: word address.
- REQ-007 SHALL have port i_AVn_Read, input, 1 bit: read request.
- REQ-008 SHALL have port i_AVn_Write, input, 1 bit: write request.
- REQ-009 SHALL have port i_AVn_WriteData, input, 32 bits: write data.
- REQ-010 SHALL have port i_AVn_ByteEnable, input, 4 bits: write byte lanes.
- REQ-011 SHALL have port o_AVn_ReadData, output, 32 bits: registered read data.
- REQ-012 SHALL have port o_AVn_ReadDataValid, output, 1 bit: one-cycle pulse qualifying ReadData.
- REQ-013 SHALL have port o_AVn_WaitRequest, output, 1 bit: the request is stalled; the master holds it.
- REQ-014 SHALL have ports o_Mem_Addr (output, 30-ADDR_SEL_BITS bits), o_Mem_RdEn, o_Mem_WrEn (output, 1 bit each), o_Mem_WrData (output, 32 bits), o_Mem_ByteEn (output, 4 bits): the single-port memory command.
- REQ-015 SHALL have port i_Mem_RdData, input, 32 bits: memory read data, valid exactly 1 cycle after o_Mem_RdEn.

Function
- REQ-016 SHALL treat port n as requesting when SlaveSel && (Read || Write); requests without SlaveSel SHALL be ignored.
- REQ-017 SHALL grant at most one port per cycle; the memory command outputs SHALL be driven combinationally from the granted port.
- REQ-018 SHALL drive o_AVn_WaitRequest=1 combinationally for a requesting port that is not granted, and 0 otherwise.
- REQ-019 SHALL use round-robin arbitration: on contention, grant the port not granted last; a registered last-grant pointer updates on every grant.
- REQ-020 SHALL grant a lone requester in the same cycle, so there is no idle bubble.
- REQ-021 SHALL treat Read and Write asserted together as a write; no read data is returned for that request.
- REQ-022 SHALL complete a granted write in its grant cycle; no response is returned.
- REQ-023 SHALL, for a granted read, pulse o_AVn_ReadDataValid and present i_Mem_RdData on o_AVn_ReadData exactly 1 cycle after the grant; otherwise ReadData=0.
- REQ-024 SHALL route returning read data by a registered read tag (valid + port), so back-to-back reads from alternating ports are returned correctly each cycle.
- REQ-025 SHALL hold the memory outputs at 0 when there is no grant.
- REQ-026 SHALL guarantee no starvation: a held request is granted within 2 cycles.
- REQ-027 SHALL ignore an address >= DEPTH for writes (o_Mem_WrEn=0) and return 0 for reads, with the Valid pulse still issued.

Reset
- REQ-028 SHALL, while i_Rst_n=0, force ReadData=0, ReadDataValid=0, the read tag invalid, and the last-grant pointer to port 1 (so port 0 wins the first contention).
- REQ-029 SHALL drop a read in flight when reset asserts; no Valid pulse SHALL follow reset release.
- REQ-030 SHALL gate WaitRequest and the memory outputs by requests only; they are combinational, and during reset WrEn and RdEn SHALL be 0.

Configuration
- REQ-031 SHALL, with macro RAM_ARB_FIXED_PRIO_EN defined, use fixed priority (port 0 always wins, no pointer register); without it, use round-robin per REQ-019. The starvation guarantee of REQ-026 applies only without the macro.

Structure
- REQ-032 SHALL place the grant encoding constants (GNT_AV0, GNT_AV1) and the read-tag width in the shared package ram_arb_pkg.
- REQ-033 SHALL contain the arbitration decision in sub-module rr_arb2 (2 requests in, one-hot grant out, last-grant pointer).

Verification
- REQ-034 SHALL cover: AV0 write 0xDEADBEEF to address 3 with ByteEnable 0xF, then AV1 read of address 3 -> WrEn pulses; 1 cycle after the read grant, o_AV1_ReadData=0xDEADBEEF with Valid=1.
- REQ-035 SHALL cover: both ports reading continuously from reset -> grants alternate 0,1,0,1; WaitRequest alternates; each Valid lands 1 cycle after its grant on the correct port.
- REQ-036 SHALL cover: the same contention with RAM_ARB_FIXED_PRIO_EN defined -> AV0 is granted every cycle and o_AV1_WaitRequest stays 1.
- REQ-037 SHALL cover: i_Rst_n pulsed low in the cycle after a granted read -> no ReadDataValid pulse; both ReadData outputs are 0.
- REQ-038 SHALL cover: a read of address DEPTH+1 -> Valid pulse with data 0; a write to DEPTH -> o_Mem_WrEn stays 0.
- REQ-039 SHALL cover: Read and Write both asserted on AV0 -> a write occurs and no Valid pulse is issued.
